// File: rtl/step_sequencer_if.sv
// Control and output bundle of the pattern step sequencer.
// The slave side is the sequencer; the master side is the register block
// that drives tempo/pattern controls and the oscillator that consumes
// the per-step outputs.
interface step_sequencer_if #(
    parameter int STEP_W = 4,
    parameter int CNT_W  = 16
);
    logic              tick;
    logic              start;
    logic              stop;
    logic [CNT_W-1:0]  tempo;
    logic [CNT_W-1:0]  gate_ticks;
    logic [STEP_W-1:0] loop_len;
    logic              wr_en;
    logic [STEP_W-1:0] wr_addr;
    logic [8:0]        wr_data;

    logic [7:0]        period;
    logic              osc_enable;
    logic              phase_clear;
    logic              gate;
    logic [STEP_W-1:0] step;
    logic              step_strobe;
    logic              busy;

    modport master (
        output tick, start, stop, tempo, gate_ticks, loop_len,
               wr_en, wr_addr, wr_data,
        input  period, osc_enable, phase_clear, gate, step, step_strobe, busy
    );

    modport slave (
        input  tick, start, stop, tempo, gate_ticks, loop_len,
               wr_en, wr_addr, wr_data,
        output period, osc_enable, phase_clear, gate, step, step_strobe, busy
    );
endinterface

// File: rtl/step_sequencer.sv
// Pattern step sequencer: walks a small RAM of per-step oscillator periods
// at a tempo counted in sample ticks, producing the oscillator wrap value,
// its count enable, a phase-clear pulse at each step start and a note gate.
module step_sequencer #(
    parameter int STEPS  = 16,
    parameter int STEP_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    step_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [7:0]        period_q, period_d;
    logic              rest_q, rest_d;
    logic              strobe_q, strobe_d;

    logic [8:0]        pattern_mem [STEPS];

    // Terminal counts; a zero tempo behaves as one tick per step. The gate
    // terminal wraps when gate_ticks is zero, which is harmless because a
    // zero gate length skips NOTE at step start.
    logic [CNT_W-1:0]  tempo_last;
    logic [CNT_W-1:0]  gate_last;
    logic [STEP_W-1:0] next_step;

    assign tempo_last = (bus.tempo == '0) ? '0 : bus.tempo - CNT_W'(1);
    assign gate_last  = bus.gate_ticks - CNT_W'(1);
    // Comparing with >= lets a loop_len lowered below the playing step wrap at once.
    assign next_step  = (step_q >= bus.loop_len) ? '0 : step_q + STEP_W'(1);

    // Pattern RAM: written any time, read only at a step start so an edit of
    // the playing step shows up on its next occurrence.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            pattern_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Next-state logic: stop beats start, start beats tick-driven advance.
    always_comb begin
        logic              begin_step;
        logic [STEP_W-1:0] target;

        state_d    = state_q;
        step_d     = step_q;
        tick_cnt_d = tick_cnt_q;
        period_d   = period_q;
        rest_d     = rest_q;
        strobe_d   = 1'b0;
        begin_step = 1'b0;
        target     = '0;

        if (bus.stop) begin
            state_d    = IDLE;
            step_d     = '0;
            tick_cnt_d = '0;
        end else if (bus.start) begin
            begin_step = 1'b1;
            target     = '0;
        end else if (state_q != IDLE && bus.tick) begin
            if (tick_cnt_q == tempo_last) begin
                begin_step = 1'b1;
                target     = next_step;
            end else begin
                if (state_q == NOTE && tick_cnt_q == gate_last) begin
                    state_d = GAP;
                end
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
        end

        if (begin_step) begin
            step_d     = target;
            period_d   = pattern_mem[target][7:0];
            rest_d     = pattern_mem[target][8];
            tick_cnt_d = '0;
            strobe_d   = 1'b1;
            state_d    = (bus.gate_ticks != '0) ? NOTE : GAP;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            tick_cnt_q <= '0;
            period_q   <= '0;
            rest_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            tick_cnt_q <= tick_cnt_d;
            period_q   <= period_d;
            rest_q     <= rest_d;
            strobe_q   <= strobe_d;
        end
    end

    // Gate comes from registered state only; the count enable qualifies it
    // with the live sample tick so the oscillator advances once per sample.
    logic gate_int;
    assign gate_int        = (state_q == NOTE) && !rest_q;
    assign bus.gate        = gate_int;
    assign bus.osc_enable  = bus.tick && gate_int;
    assign bus.period      = period_q;
    assign bus.phase_clear = strobe_q;
    assign bus.step_strobe = strobe_q;
    assign bus.step        = step_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Pattern step sequencer that drives one audio oscillator counter.
- Plays a small pattern RAM of per-step periods at a programmable tempo, measured in sample ticks.
- Per step it supplies the counter's wrap value (`period`), a per-sample count enable, a phase-clear pulse, and a note gate for the envelope stage.
- Sits between the control/register interface and the oscillator counter, in the same clock domain.

Parameters:
- STEPS, 16, number of pattern entries (power of two).
- STEP_W, 4, log2(STEPS); width of step indices.
- CNT_W, 16, width of the tempo/gate tick counters.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous and active-high
- tick  in  1  one-cycle sample-rate strobe
- start  in  1  pulse: begin or restart playback at step 0
- stop  in  1  pulse: halt playback
- tempo  in  CNT_W  ticks per step; 0 treated as 1
- gate_ticks  in  CNT_W  ticks the gate stays high at the start of each step
- loop_len  in  STEP_W  index of the last step played before wrapping to 0
- wr_en  in  1  pattern write strobe
- wr_addr  in  STEP_W  pattern write address
- wr_data  in  9  pattern entry: bit 8 = rest, bits 7:0 = period
- period  out  8  wrap value for the oscillator counter
- osc_enable  out  1  count enable for the oscillator counter
- phase_clear  out  1  one-cycle oscillator phase reset
- gate  out  1  note-on gate
- step  out  STEP_W  current step index
- step_strobe  out  1  one-cycle pulse at each step start
- busy  out  1  high when not IDLE

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE, step=0, tick_cnt=0, period=0.
  - gate, osc_enable, phase_clear, step_strobe and busy all 0.
  - Pattern RAM is not cleared by reset.
- Pattern RAM:
  - STEPS x 9 bits; write is synchronous on wr_en, legal in any state.
  - An entry is read only when a step starts. A write to the currently playing step takes effect on its next occurrence.
- States:
  - IDLE: gate=0, busy=0; period holds its last value.
  - NOTE: gate = NOT rest_latched.
  - GAP: gate=0.
- Step start: sets step to the target index, latches period and rest from RAM[target], clears tick_cnt, and pulses step_strobe=phase_clear=1 for that cycle. The next state is:
  - NOTE if gate_ticks != 0;
  - GAP if gate_ticks == 0.
- IDLE -> step start: on start, with target 0. Outputs are registered and appear the cycle after start.
- Tick counting in NOTE/GAP: tick_cnt increments by 1 on each cycle with tick=1; no change otherwise. Let eff_tempo = max(tempo,1).
- Transitions on a tick cycle, first matching rule wins:
  - tick_cnt == eff_tempo-1: step start at next_step, where next_step = 0 if step >= loop_len, else step+1. This handles loop_len lowered below step mid-play.
  - NOTE and tick_cnt == gate_ticks-1: go to GAP. If gate_ticks >= eff_tempo the gate stays high for the whole step.
- Output timing:
  - osc_enable = tick AND gate (combinational from registered gate), so the counter advances only on sample ticks while the note sounds.
  - The gate falls on the cycle after the qualifying tick.
- Priorities within one cycle: reset > stop > start > tick advance.
  - stop (any state): -> IDLE next cycle, gate=0, step=0, tick_cnt=0; no strobe.
  - start while busy: immediate restart, a step start at target 0.
  - stop and start in the same cycle: stop wins.
- tempo, gate_ticks and loop_len are sampled live every cycle; changes act on the next comparison.
- step_strobe/phase_clear never assert in IDLE; exactly one strobe per step start.

Test Plan:
- Reset sweep: reset=1 for 2 cycles mid-playback -> next cycle all outputs 0, state IDLE; previously written RAM entries still play after start.
- Basic playback: write RAM[0..3] = 9'h010, 9'h020, 9'h130, 9'h040; loop_len=3, tempo=4, gate_ticks=2, tick every cycle, pulse start ->
  - step_strobe every 4 cycles;
  - period 0x10, 0x20, 0x30, 0x40, then 0x10 again;
  - gate high 2 ticks per step, except step 2 (rest), where gate=0 and osc_enable=0 throughout.
- Sparse ticks: tick every 8th cycle, tempo=3, gate_ticks=5 -> gate high for the entire step; step advances every 24 cycles; osc_enable high only on tick cycles.
- Edge values: tempo=0, gate_ticks=0 -> a new step on every tick, each entering GAP with gate=0. Then loop_len lowered from 7 to 2 while step=5 -> next step is 0.
- Control collisions: start and stop in the same cycle while playing -> IDLE, step=0. A start pulse while at step 3 -> the next cycle shows step=0, step_strobe=1, period=RAM[0].
- Write during play: overwrite the current step's entry while it plays -> period unchanged until that step recurs, then the new value appears.
